// File: rtl/arm_one_nios_led_pwm.sv
// LED brightness/blink driver behind the LED PIO: gates the registered pattern with
// a shared PWM duty cycle and an optional blink envelope, configured over Avalon-MM.
module arm_one_nios_led_pwm #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] led_out
);

  localparam logic [1:0] ADDR_DUTY     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_BLINK    = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  logic [7:0]       duty;
  logic [15:0]      prescale;
  logic [7:0]       blink_period;
  logic             en;
  logic             blink_en;

  logic [15:0]      pre_cnt;
  logic [7:0]       pwm_cnt;
  logic [7:0]       blk_cnt;
  logic             blink_phase;
  logic [WIDTH-1:0] pattern_q;

  logic             wr;
  logic             clear;
  logic             tick;
  logic             pwm_on;
  logic             blank;

  assign wr     = chipselect && !write_n;
  // Retiming the counters whenever the timebase changes or the block is re-enabled
  // keeps the first frame after configuration fully aligned.
  assign clear  = wr && ((address == ADDR_PRESCALE) || (address == ADDR_BLINK) ||
                         ((address == ADDR_CTRL) && !en && writedata[0]));
  assign tick   = en && (pre_cnt == prescale);
  assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);
  assign blank  = blink_en && blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty         <= 8'hFF;
      prescale     <= 16'h0000;
      blink_period <= 8'h00;
      en           <= 1'b1;
      blink_en     <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_DUTY:     duty         <= writedata[7:0];
        ADDR_PRESCALE: prescale     <= writedata[15:0];
        ADDR_BLINK:    blink_period <= writedata[7:0];
        default: begin
          en       <= writedata[0];
          blink_en <= writedata[1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= 16'h0000;
      pwm_cnt     <= 8'h00;
      blk_cnt     <= 8'h00;
      blink_phase <= 1'b0;
    end else if (clear || !en) begin
      pre_cnt     <= 16'h0000;
      pwm_cnt     <= 8'h00;
      blk_cnt     <= 8'h00;
      blink_phase <= 1'b0;
    end else if (tick) begin
      pre_cnt <= 16'h0000;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        if (blk_cnt == blink_period) begin
          blk_cnt     <= 8'h00;
          blink_phase <= !blink_phase;
        end else begin
          blk_cnt <= blk_cnt + 8'd1;
        end
      end
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      led_out   <= '0;
    end else begin
      pattern_q <= pattern_in;
      led_out   <= en ? (pattern_q & {WIDTH{pwm_on && !blank}}) : '0;
    end
  end

  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DUTY:     readdata = {24'h000000, duty};
      ADDR_PRESCALE: readdata = {16'h0000, prescale};
      ADDR_BLINK:    readdata = {24'h000000, blink_period};
      default:       readdata = {30'h0, blink_en, en};
    endcase
  end

endmodule

// File: tb/tb_arm_one_nios_led_pwm.sv
// Directed bench for arm_one_nios_led_pwm: register access, PWM duty, blink,
// enable/clear behaviour and asynchronous reset, with hand-computed expectations.
module tb_arm_one_nios_led_pwm;

  logic        clk;
  logic        reset_n;
  logic [9:0]  pattern_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  led_out;

  int errors;
  int checks;

  arm_one_nios_led_pwm #(.WIDTH(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_rd [4];
    int bad;
    exp_rd[0] = 32'd255; exp_rd[1] = 32'd0; exp_rd[2] = 32'd0; exp_rd[3] = 32'd1;
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (led_out !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_led: got %h expected %h", led_out, 10'h000);
    end
    @(negedge clk);
    pattern_in = 10'h3FF;
    reset_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], rd);
      checks++;
      if (rd !== exp_rd[i]) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, rd, exp_rd[i]);
      end
    end
    step();
    checks++;
    if (led_out !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_cycle1: got %h expected %h", led_out, 10'h000);
    end
    step();
    checks++;
    if (led_out !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL reset_cycle2: got %h expected %h", led_out, 10'h3FF);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (led_out !== 10'h3FF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL reset_steady: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    write_reg(2'd0, 32'h1234_5678);
    read_reg(2'd0, rd);
    checks++;
    if (rd !== 32'h78) begin
      errors++;
      $display("[TB] FAIL reg_duty: got %h expected %h", rd, 32'h78);
    end
    @(negedge clk);
    address = 2'd0; writedata = 32'h99; chipselect = 1'b0; write_n = 1'b0;
    step();
    write_n = 1'b1;
    read_reg(2'd0, rd);
    checks++;
    if (rd !== 32'h78) begin
      errors++;
      $display("[TB] FAIL reg_no_cs: got %h expected %h", rd, 32'h78);
    end
    write_reg(2'd1, 32'hABCD_0003);
    read_reg(2'd1, rd);
    checks++;
    if (rd !== 32'h0003) begin
      errors++;
      $display("[TB] FAIL reg_prescale: got %h expected %h", rd, 32'h0003);
    end
    write_reg(2'd2, 32'hFFFF_FF05);
    read_reg(2'd2, rd);
    checks++;
    if (rd !== 32'h05) begin
      errors++;
      $display("[TB] FAIL reg_blink: got %h expected %h", rd, 32'h05);
    end
    write_reg(2'd3, 32'hFFFF_FFFE);
    read_reg(2'd3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("[TB] FAIL reg_ctrl_a: got %h expected %h", rd, 32'h2);
    end
    write_reg(2'd3, 32'h0000_0001);
    read_reg(2'd3, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("[TB] FAIL reg_ctrl_b: got %h expected %h", rd, 32'h1);
    end
  endtask

  task automatic test_pwm_duty();
    logic [9:0] exp;
    int bad;
    int high0;
    write_reg(2'd3, 32'h1);
    write_reg(2'd2, 32'h0);
    write_reg(2'd0, 32'd64);
    pattern_in = 10'h001;
    repeat (2) step();
    write_reg(2'd1, 32'h0);
    bad = 0;
    high0 = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      exp = ((i % 256) < 64) ? 10'h001 : 10'h000;
      if (led_out !== exp) bad++;
      if (i < 256 && led_out[0] === 1'b1) high0++;
    end
    checks++;
    if (high0 != 64) begin
      errors++;
      $display("[TB] FAIL pwm_high_count: got %0d expected %0d", high0, 64);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL pwm_shape: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_duty_extremes();
    logic [9:0] hist [2];
    logic [9:0] v;
    int bad;
    write_reg(2'd0, 32'd0);
    pattern_in = 10'h3FF;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (led_out !== 10'h000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL duty0_off: got %0d bad cycles expected 0", bad);
    end
    write_reg(2'd0, 32'd255);
    bad = 0;
    hist[0] = 10'h3FF;
    hist[1] = 10'h3FF;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k >= 2 && led_out !== hist[0]) bad++;
      v = 10'((k * 37 + 5) & 32'h3FF);
      pattern_in = v;
      hist[0] = hist[1];
      hist[1] = v;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL duty255_follow: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_prescale_blink();
    logic [9:0] exp;
    int bad;
    write_reg(2'd0, 32'd255);
    write_reg(2'd3, 32'h3);
    pattern_in = 10'h2AA;
    write_reg(2'd2, 32'h0);
    write_reg(2'd1, 32'h1);
    bad = 0;
    for (int i = 0; i < 1536; i++) begin
      step();
      exp = (((i / 512) % 2) == 0) ? 10'h2AA : 10'h000;
      if (led_out !== exp) bad++;
      if (i == 511) begin
        checks++;
        if (led_out !== 10'h2AA) begin
          errors++;
          $display("[TB] FAIL blink_last_on: got %h expected %h", led_out, 10'h2AA);
        end
      end
      if (i == 512) begin
        checks++;
        if (led_out !== 10'h000) begin
          errors++;
          $display("[TB] FAIL blink_first_off: got %h expected %h", led_out, 10'h000);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL blink_shape: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_enable_clear();
    logic [9:0] exp;
    int bad;
    write_reg(2'd3, 32'h1);
    write_reg(2'd0, 32'd64);
    pattern_in = 10'h3FF;
    repeat (2) step();
    write_reg(2'd1, 32'h0);
    repeat (30) step();
    checks++;
    if (led_out !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL en_before: got %h expected %h", led_out, 10'h3FF);
    end
    write_reg(2'd3, 32'h0);
    checks++;
    if (led_out !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL en_off_edge: got %h expected %h", led_out, 10'h3FF);
    end
    step();
    checks++;
    if (led_out !== 10'h000) begin
      errors++;
      $display("[TB] FAIL en_off_next: got %h expected %h", led_out, 10'h000);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (led_out !== 10'h000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL en_off_hold: got %0d bad cycles expected 0", bad);
    end
    write_reg(2'd3, 32'h1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      exp = (i < 64) ? 10'h3FF : 10'h000;
      if (led_out !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL en_restart: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'd255; exp_rd[1] = 32'd0; exp_rd[2] = 32'd0; exp_rd[3] = 32'd1;
    write_reg(2'd0, 32'd255);
    write_reg(2'd3, 32'h3);
    write_reg(2'd2, 32'h7);
    pattern_in = 10'h3FF;
    repeat (2) step();
    write_reg(2'd1, 32'h0);
    repeat (20) step();
    checks++;
    if (led_out !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL arst_before: got %h expected %h", led_out, 10'h3FF);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 10'h000) begin
      errors++;
      $display("[TB] FAIL arst_immediate: got %h expected %h", led_out, 10'h000);
    end
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], rd);
      checks++;
      if (rd !== exp_rd[i]) begin
        errors++;
        $display("[TB] FAIL arst_reg%0d: got %h expected %h", i, rd, exp_rd[i]);
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    pattern_in = 10'h000;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset();
    test_registers();
    test_pwm_duty();
    test_duty_extremes();
    test_prescale_blink();
    test_enable_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
